// File: rtl/regfile8_sync.sv
// regfile8_sync: 8-entry register file with a decoded one-hot write select,
// two independent registered read ports (1-cycle latency) and a
// write-to-read bypass when a read targets the register being written.
module regfile8_sync #(
    parameter int WIDTH = 16
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             WrEn,
    input  logic [2:0]       WrAddr,
    input  logic [WIDTH-1:0] WrData,
    input  logic             RdEnA,
    input  logic [2:0]       RdAddrA,
    input  logic             RdEnB,
    input  logic [2:0]       RdAddrB,
    output logic [WIDTH-1:0] DataA,
    output logic             ValidA,
    output logic [WIDTH-1:0] DataB,
    output logic             ValidB,
    output logic [7:0]       WrOneHot
);

    // Storage and per-port combinational read sources.
    logic [WIDTH-1:0] regs_r [8];
    logic [7:0]       wr_onehot_s;
    logic [WIDTH-1:0] rd_src_a_s;
    logic [WIDTH-1:0] rd_src_b_s;

    // 3-to-8 decode; any address value outside 0..7 (X/Z) decodes to no write.
    function automatic logic [7:0] decode_wr(input logic en, input logic [2:0] addr);
        logic [7:0] sel;
        sel = 8'h00;
        if (en) begin
            case (addr)
                3'd0:    sel = 8'h01;
                3'd1:    sel = 8'h02;
                3'd2:    sel = 8'h04;
                3'd3:    sel = 8'h08;
                3'd4:    sel = 8'h10;
                3'd5:    sel = 8'h20;
                3'd6:    sel = 8'h40;
                3'd7:    sel = 8'h80;
                default: sel = 8'h00;
            endcase
        end else begin
            sel = 8'h00;
        end
        return sel;
    endfunction

    // Write select is forced to zero while reset is asserted.
    always_comb begin
        wr_onehot_s = 8'h00;
        if (Resetn) begin
            wr_onehot_s = decode_wr(WrEn, WrAddr);
        end else begin
            wr_onehot_s = 8'h00;
        end
    end

    assign WrOneHot = wr_onehot_s;

    // Port A read source: bypass the in-flight write data on address match.
    always_comb begin
        rd_src_a_s = regs_r[RdAddrA];
        if (wr_onehot_s[RdAddrA]) begin
            rd_src_a_s = WrData;
        end else begin
            rd_src_a_s = regs_r[RdAddrA];
        end
    end

    // Port B read source: same bypass rule as port A.
    always_comb begin
        rd_src_b_s = regs_r[RdAddrB];
        if (wr_onehot_s[RdAddrB]) begin
            rd_src_b_s = WrData;
        end else begin
            rd_src_b_s = regs_r[RdAddrB];
        end
    end

    // Register array: cleared by reset, otherwise written through the one-hot select.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            for (int k = 0; k < 8; k++) begin
                regs_r[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (wr_onehot_s[k]) begin
                    regs_r[k] <= WrData;
                end
            end
        end
    end

    // Port A output register: capture on request, hold data and drop valid otherwise.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            DataA  <= '0;
            ValidA <= 1'b0;
        end else if (RdEnA) begin
            DataA  <= rd_src_a_s;
            ValidA <= 1'b1;
        end else begin
            ValidA <= 1'b0;
        end
    end

    // Port B output register: independent copy of the port A behaviour.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            DataB  <= '0;
            ValidB <= 1'b0;
        end else if (RdEnB) begin
            DataB  <= rd_src_b_s;
            ValidB <= 1'b1;
        end else begin
            ValidB <= 1'b0;
        end
    end

endmodule
